io_intr_ctrl: RTL and testbench

Parametrised successor to the single-interrupt IO block. It provides a byte-addressable, big-endian IO memory window and a register bank in the top 256 bytes of the address space. The register bank serves NUM_CH interrupt channels; each channel is fed by an external request line and a programmable reload timer. The block sits on the CPU IO bus (io_cs/io_rd/io_wr) and drives the CPU intr/int_ack handshake, with a vector identifying the channel being serviced.

---
 rtl/io_intr_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_io_intr_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: big-endian byte-addressable IO memory window with an
// interrupt controller register bank in the top 256 bytes of the space.
//
// Ports:
//   clock, reset        single clock, async active-high reset
//   io_cs/io_rd/io_wr   CPU IO bus strobes
//   Address             byte address of the MSB of the accessed word
//   IO_in / IO_out      write data / read data (Z unless io_cs & io_rd)
//   ext_irq[NUM_CH]     level requests, rising-edge detected
//   int_ack             CPU acknowledge
//   intr, int_vec       interrupt request and channel being serviced
//
// Register map (offset = Address[7:0], word aligned only):
//   0x00 PENDING (W1C)  0x04 MASK  0x08 STATUS {in_service@31, int_vec}
//   0x10+4i RELOAD[i]   0x80+4i COUNT[i] (RO)

// Per-channel state: edge detector, reload timer and pending flag.
module io_intr_chan #(
  parameter int TIMER_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               irq,
  input  logic               reload_we,
  input  logic [TIMER_W-1:0] reload_wdata,
  input  logic               clr,
  output logic               pending,
  output logic               set_now,
  output logic [TIMER_W-1:0] reload,
  output logic [TIMER_W-1:0] count
);
  logic irq_q;
  logic edge_hit, timer_hit;

  assign edge_hit  = irq & ~irq_q;
  assign timer_hit = (reload != '0) && (count == TIMER_W'(1));
  assign set_now   = edge_hit | timer_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
      reload  <= '0;
      count   <= '0;
    end else begin
      irq_q <= irq;
      // A new request on the same edge as a clear must not be lost.
      if (set_now)  pending <= 1'b1;
      else if (clr) pending <= 1'b0;
      if (reload_we) reload <= reload_wdata;
      if (reload_we)                  count <= reload_wdata;
      else if (reload == '0)          count <= '0;
      else if (count <= TIMER_W'(1))  count <= reload;
      else                            count <= count - 1'b1;
    end
  end
endmodule

module io_intr_ctrl #(
  parameter  int ADDR_W  = 12,
  parameter  int DATA_W  = 32,
  parameter  int NUM_CH  = 4,
  parameter  int TIMER_W = 16,
  localparam int VEC_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_cs,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] IO_in,
  output logic [DATA_W-1:0] IO_out,
  input  logic [NUM_CH-1:0] ext_irq,
  input  logic              int_ack,
  output logic              intr,
  output logic [VEC_W-1:0]  int_vec
);
  localparam int NB       = DATA_W / 8;
  // The memory array covers only the non-register part of the space;
  // words running past its end wrap to byte 0 instead of hitting registers.
  localparam int MEM_SIZE = (1 << ADDR_W) - 256;

  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT} state_t;

  logic [7:0] mem [MEM_SIZE];

  logic [7:0]  off;
  logic        is_reg, aligned, reg_we, mem_we, w1c_we, mask_we;
  logic [NUM_CH-1:0] pending, set_now, mask, ack_clr, active;
  logic [NUM_CH-1:0][TIMER_W-1:0] reload, count;
  logic [DATA_W-1:0] reg_rdata, mem_rdata;

  state_t            state, state_nx;
  logic              intr_nx, in_service, insvc_nx, removed;
  logic [VEC_W-1:0]  vec_nx, winner;

  assign off     = Address[7:0];
  assign is_reg  = &Address[ADDR_W-1:8];
  assign aligned = (Address[1:0] == 2'b00);
  assign reg_we  = io_cs & io_wr & is_reg & aligned;
  assign mem_we  = io_cs & io_wr & ~is_reg;
  assign w1c_we  = reg_we && (off == 8'h00);
  assign mask_we = reg_we && (off == 8'h04);
  assign active  = pending & mask;

  function automatic logic [ADDR_W-1:0] mem_idx(input logic [ADDR_W-1:0] base, input int k);
    logic [ADDR_W:0] a;
    a = {1'b0, base} + (ADDR_W+1)'(k);
    if (a >= (ADDR_W+1)'(MEM_SIZE)) a = a - (ADDR_W+1)'(MEM_SIZE);
    return a[ADDR_W-1:0];
  endfunction

  // ---------------- memory window ----------------
  always_ff @(posedge clock) begin
    if (mem_we)
      for (int k = 0; k < NB; k++)
        mem[mem_idx(Address, k)] <= IO_in[DATA_W-1-8*k -: 8];
  end

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < NB; k++)
      mem_rdata[DATA_W-1-8*k -: 8] = mem[mem_idx(Address, k)];
  end

  // ---------------- channels ----------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_intr_chan #(.TIMER_W(TIMER_W)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .irq         (ext_irq[i]),
      .reload_we   (reg_we && (off == 8'(16 + 4*i))),
      .reload_wdata(IO_in[TIMER_W-1:0]),
      .clr         ((w1c_we & IO_in[i]) | ack_clr[i]),
      .pending     (pending[i]),
      .set_now     (set_now[i]),
      .reload      (reload[i]),
      .count       (count[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        mask <= '0;
    else if (mask_we) mask <= IO_in[NUM_CH-1:0];
  end

  // ---------------- register read mux ----------------
  // STATUS bit 31 assumes DATA_W >= 32.
  always_comb begin
    reg_rdata = '0;
    if (aligned) begin
      case (off)
        8'h00: reg_rdata[NUM_CH-1:0] = pending;
        8'h04: reg_rdata[NUM_CH-1:0] = mask;
        8'h08: begin
          reg_rdata[31]         = in_service;
          reg_rdata[VEC_W-1:0]  = int_vec;
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (off == 8'(16 + 4*i))  reg_rdata[TIMER_W-1:0] = reload[i];
        if (off == 8'(128 + 4*i)) reg_rdata[TIMER_W-1:0] = count[i];
      end
    end
  end

  assign IO_out = (io_cs && io_rd) ? (is_reg ? reg_rdata : mem_rdata) : {DATA_W{1'bz}};

  // ---------------- handshake FSM ----------------
  always_comb begin
    winner = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (active[i]) winner = VEC_W'(i);
  end

  // Latched channel disappears this edge through software (W1C or mask),
  // unless a fresh request re-sets it on the same edge.
  assign removed = (w1c_we && IO_in[int_vec] && !set_now[int_vec]) ||
                   (mask_we && !IO_in[int_vec]);

  always_comb begin
    state_nx = state;
    intr_nx  = intr;
    vec_nx   = int_vec;
    insvc_nx = in_service;
    ack_clr  = '0;
    case (state)
      IDLE: if (|active) begin
        vec_nx   = winner;
        intr_nx  = 1'b1;
        state_nx = REQ;
      end
      REQ: if (int_ack) begin
        ack_clr[int_vec] = 1'b1;
        intr_nx  = 1'b0;
        insvc_nx = 1'b1;
        state_nx = ACKWAIT;
      end else if (removed) begin
        intr_nx  = 1'b0;
        state_nx = IDLE;
      end
      ACKWAIT: if (!int_ack) begin
        insvc_nx = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      intr       <= 1'b0;
      int_vec    <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nx;
      intr       <= intr_nx;
      int_vec    <= vec_nx;
      in_service <= insvc_nx;
    end
  end
endmodule

// File: tb/tb_io_intr_ctrl.sv
module tb_io_intr_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
  logic [11:0] Address = '0;
  logic [31:0] IO_in = '0;
  wire  [31:0] IO_out;
  logic [3:0]  ext_irq = '0;
  logic        int_ack = 1'b0;
  wire         intr;
  wire  [1:0]  int_vec;

  int checks = 0;
  int errors = 0;

  io_intr_ctrl #(.ADDR_W(12), .DATA_W(32), .NUM_CH(4), .TIMER_W(16)) dut (
    .clock(clock), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
    .Address(Address), .IO_in(IO_in), .IO_out(IO_out), .ext_irq(ext_irq),
    .int_ack(int_ack), .intr(intr), .int_vec(int_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          w;
    logic [11:0] a;
    logic [31:0] d;  // write data, or expected read data
  } vec_t;
  vec_t tbl[28];

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    io_cs = 1'b1; io_rd = 1'b1; Address = a;
    #1 d = IO_out;
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  // Drive a write from a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; Address = a; IO_in = d;
    @(negedge clock);
    io_cs = 1'b0; io_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt_exp [6];
    tbl[0]  = '{1'b1, 12'h000, 32'h00000000};
    tbl[1]  = '{1'b1, 12'h010, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 12'h014, 32'h11223344};
    tbl[3]  = '{1'b0, 12'h010, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 12'h011, 32'hADBEEF11};
    tbl[5]  = '{1'b0, 12'h012, 32'hBEEF1122};
    tbl[6]  = '{1'b0, 12'h013, 32'hEF112233};
    tbl[7]  = '{1'b1, 12'hEFA, 32'h01020304};
    tbl[8]  = '{1'b1, 12'hEFE, 32'hCAFEF00D};
    tbl[9]  = '{1'b0, 12'hEFE, 32'hCAFEF00D};
    tbl[10] = '{1'b0, 12'h000, 32'hF00D0000};
    tbl[11] = '{1'b0, 12'hEFC, 32'h0304CAFE};
    tbl[12] = '{1'b0, 12'hF00, 32'h00000000};
    tbl[13] = '{1'b1, 12'hF04, 32'hFFFFFFFF};
    tbl[14] = '{1'b0, 12'hF04, 32'h0000000F};
    tbl[15] = '{1'b0, 12'hF05, 32'h00000000};
    tbl[16] = '{1'b1, 12'hF06, 32'h00000000};
    tbl[17] = '{1'b0, 12'hF04, 32'h0000000F};
    tbl[18] = '{1'b1, 12'hF04, 32'h00000000};
    tbl[19] = '{1'b0, 12'hF02, 32'h00000000};
    tbl[20] = '{1'b1, 12'hF1C, 32'hFFFF1234};
    tbl[21] = '{1'b0, 12'hF1C, 32'h00001234};
    tbl[22] = '{1'b0, 12'hF8C, 32'h00001233};
    tbl[23] = '{1'b1, 12'hF1C, 32'h00000000};
    tbl[24] = '{1'b0, 12'hF8C, 32'h00000000};
    tbl[25] = '{1'b0, 12'hF0C, 32'h00000000};
    tbl[26] = '{1'b0, 12'hF9C, 32'h00000000};
    tbl[27] = '{1'b0, 12'hF08, 32'h00000000};
    cnt_exp = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd5};

    // Reset state, before any clock edge
    #2;
    chk("rst_intr", {31'b0, intr}, 32'd0);
    chk("rst_vec", {30'b0, int_vec}, 32'd0);
    chk_rd("rst_pending", 12'hF00, 32'd0);
    chk_rd("rst_status", 12'hF08, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven memory and register accesses
    for (int i = 0; i < 28; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      else begin
        chk_rd($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d);
        @(negedge clock);
      end
    end

    // Edge interrupt on channel 2
    wr(12'hF04, 32'hF);
    ext_irq[2] = 1'b1;
    @(negedge clock);
    chk_rd("edge_pend", 12'hF00, 32'h4);
    chk("edge_intr_early", {31'b0, intr}, 32'd0);
    @(negedge clock);
    chk("edge_intr", {31'b0, intr}, 32'd1);
    chk("edge_vec", {30'b0, int_vec}, 32'd2);
    chk_rd("edge_status", 12'hF08, 32'h2);
    int_ack = 1'b1;
    @(negedge clock);
    chk("ack_intr", {31'b0, intr}, 32'd0);
    chk_rd("ack_pend", 12'hF00, 32'h0);
    chk_rd("ack_status", 12'hF08, 32'h80000002);
    int_ack = 1'b0;
    repeat (4) @(negedge clock);
    chk("hold_intr", {31'b0, intr}, 32'd0);
    chk_rd("hold_pend", 12'hF00, 32'h0);
    ext_irq = '0;
    @(negedge clock);

    // Priority and vector latching
    ext_irq = 4'b1010;
    @(negedge clock);
    chk_rd("pri_pend", 12'hF00, 32'hA);
    @(negedge clock);
    chk("pri_vec1", {30'b0, int_vec}, 32'd1);
    ext_irq[0] = 1'b1;
    @(negedge clock);
    chk("pri_latch", {30'b0, int_vec}, 32'd1);
    chk("pri_latch_intr", {31'b0, intr}, 32'd1);
    chk_rd("pri_pend2", 12'hF00, 32'hB);
    int_ack = 1'b1;
    @(negedge clock);
    chk_rd("pri_pend3", 12'hF00, 32'h9);
    int_ack = 1'b0;
    @(negedge clock);
    chk("pri_gap", {31'b0, intr}, 32'd0);
    @(negedge clock);
    chk("pri_vec0", {30'b0, int_vec}, 32'd0);
    chk("pri_intr0", {31'b0, intr}, 32'd1);
    int_ack = 1'b1; @(negedge clock);
    int_ack = 1'b0; @(negedge clock);
    @(negedge clock);
    chk("pri_vec3", {30'b0, int_vec}, 32'd3);
    int_ack = 1'b1; @(negedge clock);
    int_ack = 1'b0; @(negedge clock);
    @(negedge clock);
    chk("pri_done", {31'b0, intr}, 32'd0);
    chk_rd("pri_pend_done", 12'hF00, 32'h0);
    ext_irq = '0;
    @(negedge clock);

    // Reload timer on channel 0
    wr(12'hF04, 32'h1);
    wr(12'hF10, 32'd5);
    chk_rd("tmr_pend0", 12'hF00, 32'h0);
    for (int j = 0; j < 6; j++) begin
      chk_rd($sformatf("tmr_cnt%0d", j), 12'hF80, cnt_exp[j]);
      if (j < 5) @(negedge clock);
    end
    chk_rd("tmr_pend1", 12'hF00, 32'h1);
    chk("tmr_intr_late", {31'b0, intr}, 32'd0);
    @(negedge clock);
    chk("tmr_intr", {31'b0, intr}, 32'd1);
    chk_rd("tmr_cnt_k1", 12'hF80, 32'd4);
    int_ack = 1'b1;
    @(negedge clock);
    chk_rd("tmr_pend_k2", 12'hF00, 32'h0);
    int_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_rd("tmr_pend_k4", 12'hF00, 32'h0);
    chk_rd("tmr_cnt_k4", 12'hF80, 32'd1);
    @(negedge clock);
    chk_rd("tmr_pend_k5", 12'hF00, 32'h1);
    wr(12'hF10, 32'd0);
    chk_rd("tmr_cnt_off", 12'hF80, 32'd0);
    int_ack = 1'b1; @(negedge clock);
    int_ack = 1'b0;
    repeat (8) @(negedge clock);
    chk_rd("tmr_off_pend", 12'hF00, 32'h0);
    chk_rd("tmr_off_cnt", 12'hF80, 32'd0);
    chk("tmr_off_intr", {31'b0, intr}, 32'd0);

    // Collisions
    wr(12'hF04, 32'h0);
    ext_irq[1] = 1'b1; @(negedge clock);
    ext_irq[1] = 1'b0; @(negedge clock);
    ext_irq[1] = 1'b1;
    wr(12'hF00, 32'h2);
    chk_rd("col_set_wins", 12'hF00, 32'h2);
    ext_irq[1] = 1'b0;
    wr(12'hF00, 32'h2);
    chk_rd("col_w1c", 12'hF00, 32'h0);
    ext_irq[1] = 1'b1;
    @(negedge clock);
    wr(12'hF04, 32'hF);
    @(negedge clock);
    chk("msk_intr", {31'b0, intr}, 32'd1);
    wr(12'hF04, 32'hD);
    chk("msk_drop", {31'b0, intr}, 32'd0);
    @(negedge clock);
    chk("msk_stay", {31'b0, intr}, 32'd0);
    chk_rd("msk_pend", 12'hF00, 32'h2);

    // Asynchronous reset mid-handshake
    wr(12'hF04, 32'hF);
    @(negedge clock);
    chk("rstm_intr_pre", {31'b0, intr}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstm_intr", {31'b0, intr}, 32'd0);
    chk("rstm_vec", {30'b0, int_vec}, 32'd0);
    chk_rd("rstm_pend", 12'hF00, 32'h0);
    chk_rd("rstm_mask", 12'hF04, 32'h0);
    ext_irq = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rstm_after", {31'b0, intr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
